// File: rtl/payload_router.sv
// Payload router: strips the 4-byte packet header and steers payload bytes to
// one of two packet RAM write ports, reporting length/type/error at packet end.
module payload_router #(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              aclr,
    input  logic [7:0]        datain,
    input  logic              ena,
    input  logic              is_type_1,
    input  logic              is_type_2,
    output logic [7:0]        wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_en_1,
    output logic              wr_en_2,
    output logic              pkt_done,
    output logic [ADDR_W:0]   pkt_len,
    output logic [1:0]        pkt_type,
    output logic              pkt_err,
    output logic              pkt_ovf,
    output logic [1:0]        state_dbg
);

    // Handshake: ena qualifies datain every cycle (no backpressure); a write
    // strobe is a one-cycle valid for wr_data/wr_addr, pkt_done a one-cycle
    // valid for the held pkt_* status registers.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        DROP    = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    state_t            state, state_n;
    logic [2:0]        hdr_cnt, hdr_cnt_n;
    logic [ADDR_W:0]   pay_cnt, pay_cnt_n;
    logic              sel, sel_n;
    logic              ovf_seen, ovf_seen_n;

    logic [7:0]        wr_data_n;
    logic [ADDR_W-1:0] wr_addr_n;
    logic              wr_en_1_n, wr_en_2_n;
    logic              pkt_done_n;
    logic [ADDR_W:0]   pkt_len_n;
    logic [1:0]        pkt_type_n;
    logic              pkt_err_n, pkt_ovf_n;

    assign state_dbg = state;

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            state    <= IDLE;
            hdr_cnt  <= '0;
            pay_cnt  <= '0;
            sel      <= 1'b0;
            ovf_seen <= 1'b0;
            wr_data  <= '0;
            wr_addr  <= '0;
            wr_en_1  <= 1'b0;
            wr_en_2  <= 1'b0;
            pkt_done <= 1'b0;
            pkt_len  <= '0;
            pkt_type <= '0;
            pkt_err  <= 1'b0;
            pkt_ovf  <= 1'b0;
        end else begin
            state    <= state_n;
            hdr_cnt  <= hdr_cnt_n;
            pay_cnt  <= pay_cnt_n;
            sel      <= sel_n;
            ovf_seen <= ovf_seen_n;
            wr_data  <= wr_data_n;
            wr_addr  <= wr_addr_n;
            wr_en_1  <= wr_en_1_n;
            wr_en_2  <= wr_en_2_n;
            pkt_done <= pkt_done_n;
            pkt_len  <= pkt_len_n;
            pkt_type <= pkt_type_n;
            pkt_err  <= pkt_err_n;
            pkt_ovf  <= pkt_ovf_n;
        end
    end

    always_comb begin
        state_n    = state;
        hdr_cnt_n  = hdr_cnt;
        pay_cnt_n  = pay_cnt;
        sel_n      = sel;
        ovf_seen_n = ovf_seen;
        wr_data_n  = wr_data;
        wr_addr_n  = wr_addr;
        wr_en_1_n  = 1'b0;
        wr_en_2_n  = 1'b0;
        pkt_done_n = 1'b0;
        pkt_len_n  = pkt_len;
        pkt_type_n = pkt_type;
        pkt_err_n  = pkt_err;
        pkt_ovf_n  = pkt_ovf;

        case (state)
            IDLE: begin
                if (ena) begin
                    state_n    = HEADER;
                    hdr_cnt_n  = 3'd1;
                    pay_cnt_n  = '0;
                    sel_n      = 1'b0;
                    ovf_seen_n = 1'b0;
                end
            end

            HEADER: begin
                if (!ena) begin
                    state_n    = IDLE;
                    pkt_done_n = 1'b1;
                    pkt_len_n  = '0;
                    pkt_type_n = 2'b00;
                    pkt_err_n  = 1'b1;
                    pkt_ovf_n  = 1'b0;
                end else if (hdr_cnt == 3'd4) begin
                    // Byte index 4: the only cycle the decoder flags are sampled.
                    if (is_type_1 != is_type_2) begin
                        state_n   = PAYLOAD;
                        sel_n     = is_type_2;
                        wr_data_n = datain;
                        wr_addr_n = '0;
                        wr_en_1_n = is_type_1;
                        wr_en_2_n = is_type_2;
                        pay_cnt_n = {{ADDR_W{1'b0}}, 1'b1};
                    end else begin
                        state_n = DROP;
                    end
                end else begin
                    hdr_cnt_n = hdr_cnt + 3'd1;
                end
            end

            PAYLOAD: begin
                if (!ena) begin
                    state_n    = IDLE;
                    pkt_done_n = 1'b1;
                    pkt_len_n  = pay_cnt;
                    pkt_type_n = sel ? 2'b10 : 2'b01;
                    pkt_err_n  = ovf_seen;
                    pkt_ovf_n  = ovf_seen;
                end else if (pay_cnt != MAX_LEN) begin
                    wr_data_n = datain;
                    wr_addr_n = pay_cnt[ADDR_W-1:0];
                    wr_en_1_n = ~sel;
                    wr_en_2_n = sel;
                    pay_cnt_n = pay_cnt + 1'b1;
                end else begin
                    // Count holds at MAX_LEN so it never wraps into valid addresses.
                    ovf_seen_n = 1'b1;
                end
            end

            DROP: begin
                if (!ena) begin
                    state_n    = IDLE;
                    pkt_done_n = 1'b1;
                    pkt_len_n  = '0;
                    pkt_type_n = 2'b00;
                    pkt_err_n  = 1'b1;
                    pkt_ovf_n  = 1'b0;
                end
            end

            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_payload_router.sv
// Bench for payload_router (ADDR_W=4): directed packets, expected writes and
// end-of-packet reports queued at issue time and checked by a monitor.
module tb_payload_router;

    localparam int ADDR_W = 4;

    logic              clock;
    logic              aclr;
    logic [7:0]        datain;
    logic              ena;
    logic              is_type_1;
    logic              is_type_2;
    logic [7:0]        wr_data;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en_1;
    logic              wr_en_2;
    logic              pkt_done;
    logic [ADDR_W:0]   pkt_len;
    logic [1:0]        pkt_type;
    logic              pkt_err;
    logic              pkt_ovf;
    logic [1:0]        state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    // {wr_en_2, wr_en_1, wr_addr, wr_data}
    logic [13:0] wr_q[$];
    // {pkt_len, pkt_type, pkt_err, pkt_ovf}
    logic [8:0]  done_q[$];

    payload_router #(.ADDR_W(ADDR_W)) dut (
        .clock     (clock),
        .aclr      (aclr),
        .datain    (datain),
        .ena       (ena),
        .is_type_1 (is_type_1),
        .is_type_2 (is_type_2),
        .wr_data   (wr_data),
        .wr_addr   (wr_addr),
        .wr_en_1   (wr_en_1),
        .wr_en_2   (wr_en_2),
        .pkt_done  (pkt_done),
        .pkt_len   (pkt_len),
        .pkt_type  (pkt_type),
        .pkt_err   (pkt_err),
        .pkt_ovf   (pkt_ovf),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // driver tasks
    task automatic drive(input logic [7:0] b, input logic e, input logic t1, input logic t2);
        @(posedge clock);
        #1;
        datain    = b;
        ena       = e;
        is_type_1 = t1;
        is_type_2 = t2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push_done(input logic [ADDR_W:0] len, input logic [1:0] typ,
                             input logic err, input logic ovf);
        done_q.push_back({len, typ, err, ovf});
    endtask

    // Header bytes {hdr0,00,00,00} with random flags, then n payload bytes.
    task automatic send_pkt(input logic [7:0] hdr0, input int n, input logic t1,
                            input logic t2, input logic [7:0] base, input logic scramble);
        logic f1, f2;
        drive(hdr0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int i = 1; i < 4; i++)
            drive(8'h00, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int i = 0; i < n; i++) begin
            f1 = t1;
            f2 = t2;
            if (scramble && i > 0) begin
                f1 = 1'($urandom_range(0, 1));
                f2 = 1'($urandom_range(0, 1));
            end
            drive(8'(base + i), 1'b1, f1, f2);
            if ((t1 != t2) && i < (1 << ADDR_W))
                wr_q.push_back({t2, t1, 4'(i), 8'(base + i)});
        end
    endtask

    // scoreboard monitor
    always @(negedge clock) begin
        if (!aclr) begin
            if (wr_en_1 && wr_en_2) check("both_strobes", 32'd1, 32'd0);
            if (wr_en_1 || wr_en_2) begin
                if (wr_q.size() == 0)
                    check("unexpected_write", {18'd0, wr_en_2, wr_en_1, wr_addr, wr_data}, 32'd0);
                else
                    check("write", {18'd0, wr_en_2, wr_en_1, wr_addr, wr_data},
                          {18'd0, wr_q.pop_front()});
            end
            if (pkt_done) begin
                if (done_q.size() == 0)
                    check("unexpected_done", {22'd0, 1'b1, pkt_len, pkt_type, pkt_err, pkt_ovf}, 32'd0);
                else
                    check("pkt_status", {23'd0, pkt_len, pkt_type, pkt_err, pkt_ovf},
                          {23'd0, done_q.pop_front()});
            end
        end
    end

    function automatic logic [31:0] all_outputs();
        return {6'd0, wr_data, wr_addr, wr_en_1, wr_en_2, pkt_done,
                pkt_len, pkt_type, pkt_err, pkt_ovf, state_dbg};
    endfunction

    initial begin
        aclr      = 1'b1;
        ena       = 1'b0;
        datain    = 8'h00;
        is_type_1 = 1'b0;
        is_type_2 = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_outputs", all_outputs(), 32'd0);
        aclr = 1'b0;
        idle(2);

        // Type-1: A1@0, A2@1, A3@2
        send_pkt(8'h00, 3, 1'b1, 1'b0, 8'hA1, 1'b0);
        push_done(5'd3, 2'b01, 1'b0, 1'b0);
        idle(2);

        // Type-2: 55@0
        send_pkt(8'h01, 1, 1'b0, 1'b1, 8'h55, 1'b0);
        push_done(5'd1, 2'b10, 1'b0, 1'b0);
        idle(2);

        // Unknown type, then both flags set: dropped
        send_pkt(8'h07, 6, 1'b0, 1'b0, 8'h30, 1'b0);
        push_done(5'd0, 2'b00, 1'b1, 1'b0);
        idle(1);
        send_pkt(8'h07, 2, 1'b1, 1'b1, 8'h40, 1'b0);
        push_done(5'd0, 2'b00, 1'b1, 1'b0);
        idle(2);

        // Short 3-byte frame, one idle cycle, then back-to-back type-1
        for (int i = 0; i < 3; i++) drive(8'h11, 1'b1, 1'b1, 1'b0);
        idle(1);
        push_done(5'd0, 2'b00, 1'b1, 1'b0);
        send_pkt(8'h00, 2, 1'b1, 1'b0, 8'hC0, 1'b0);
        push_done(5'd2, 2'b01, 1'b0, 1'b0);
        idle(2);

        // Overflow: 20 payload bytes, flags scrambled after the decision byte
        send_pkt(8'h00, 20, 1'b1, 1'b0, 8'h10, 1'b1);
        push_done(5'd16, 2'b01, 1'b1, 1'b1);
        idle(2);

        // Exactly 16 payload bytes: full but not overflowed
        send_pkt(8'h00, 16, 1'b0, 1'b1, 8'h60, 1'b0);
        push_done(5'd16, 2'b10, 1'b0, 1'b0);
        idle(2);

        // Mid-packet reset during payload byte 2
        for (int i = 0; i < 4; i++) drive(8'h00, 1'b1, 1'b0, 1'b0);
        drive(8'h70, 1'b1, 1'b1, 1'b0);
        wr_q.push_back({2'b01, 4'd0, 8'h70});
        drive(8'h71, 1'b1, 1'b1, 1'b0);
        @(posedge clock);
        #1;
        aclr   = 1'b1;
        datain = 8'h72;
        #1;
        check("reset_mid_packet", all_outputs(), 32'd0);
        @(posedge clock);
        #1;
        ena  = 1'b0;
        @(posedge clock);
        #1;
        aclr = 1'b0;
        idle(2);

        send_pkt(8'h01, 2, 1'b0, 1'b1, 8'h90, 1'b0);
        push_done(5'd2, 2'b10, 1'b0, 1'b0);
        idle(5);

        check("write_queue_drained", 32'(wr_q.size()), 32'd0);
        check("done_queue_drained", 32'(done_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/payload_router.md
# payload_router

Downstream stage of the packet header type decoder. Consumes the same framed byte stream (`datain` qualified by `ena`) together with the decoder's `is_type_1` / `is_type_2` flags. Discards the 4-byte header and steers payload bytes into one of two packet RAM write ports. At end of packet it reports length, type and error status.

## Interface
- `ADDR_W`, default 8: payload RAM address width. Maximum payload is 2^ADDR_W bytes.

- `clock`  in  1  system clock; all state changes on the rising edge.
- `aclr`  in  1  asynchronous, active-high reset.
- `datain`  in  8  stream byte, valid when `ena`=1.
- `ena`  in  1  packet frame; high for every byte of a packet, low for at least 1 cycle between packets.
- `is_type_1`  in  1  header decoder flag; valid from the 5th `ena` cycle of the packet.
- `is_type_2`  in  1  header decoder flag; same timing as `is_type_1`.
- `wr_data`  out  8  payload byte to RAM.
- `wr_addr`  out  ADDR_W  packet-relative payload address.
- `wr_en_1`  out  1  write strobe, type-1 RAM.
- `wr_en_2`  out  1  write strobe, type-2 RAM.
- `pkt_done`  out  1  one-cycle end-of-packet pulse.
- `pkt_len`  out  ADDR_W+1  payload bytes written; valid with `pkt_done`, held until the next `pkt_done`.
- `pkt_type`  out  2  01 = type 1, 10 = type 2, 00 = dropped; held like `pkt_len`.
- `pkt_err`  out  1  short, dropped or overflowed packet; held like `pkt_len`.
- `pkt_ovf`  out  1  payload exceeded 2^ADDR_W bytes; held like `pkt_len`.

## Operation
- **Reset:** while `aclr`=1, all outputs are 0, state is IDLE, and the byte counter and address are 0.
- **States:** IDLE, HEADER, PAYLOAD, DROP.
- **IDLE → HEADER:** on an `ena`=1 cycle. That byte is header byte 0.
- **HEADER:** counts header bytes 0..3. Nothing is written.
- **Type decision:** made on the 5th `ena` cycle (byte index 4, first payload byte), by sampling the flags.
  - `is_type_1`=1 and `is_type_2`=0 → PAYLOAD, select RAM 1.
  - `is_type_2`=1 and `is_type_1`=0 → PAYLOAD, select RAM 2.
  - Neither or both set → DROP.
  - The byte at index 4 is written in the PAYLOAD case.
- **PAYLOAD:**
  - Each `ena` byte at index k≥4 is written at `wr_addr` = k−4, while k−4 < 2^ADDR_W.
  - Bytes beyond that are discarded. `pkt_ovf` is latched internally and `pkt_len` saturates at 2^ADDR_W.
- **DROP:** all bytes are discarded until `ena`=0.
- **End of packet:** the first `ena`=0 cycle while not in IDLE.
  - Return to IDLE.
  - Publish the status registers and pulse `pkt_done`.
- **Short packet:** `ena` falls during HEADER (fewer than 5 bytes). Report `pkt_type`=00, `pkt_len`=0, `pkt_err`=1.
- **Error flag:** `pkt_err` = short | dropped | overflow.
- **Selector changes:** `is_type_*` changes after the decision cycle are ignored.
- **Width:** the internal byte counter saturates and must not wrap back into a valid address range.

## Timing
- **Write latency:** a byte accepted on cycle N (`ena`=1) appears on cycle N+1.
  - `wr_en_x`=1 for exactly that cycle.
  - `wr_data` and `wr_addr` are registered with it.
- **Write idle:** at most one of `wr_en_1` / `wr_en_2` is high in any cycle. Both are low in IDLE, HEADER and DROP, and on overflowed bytes.
- **End-of-packet timing:** if the last byte arrives on cycle N and `ena`=0 on N+1:
  - the last write strobe is on N+1;
  - `pkt_done`=1 on N+2;
  - `pkt_len`, `pkt_type`, `pkt_err` and `pkt_ovf` update on N+2.
- **Back-to-back packets:** `ena` may rise on the cycle `pkt_done` is high. That cycle is byte 0 of the new packet, and the held status is not disturbed until that packet ends.
- **Reset mid-packet:** asynchronous clear.
  - Any pending write or `pkt_done` is lost.
  - After release, the block waits in IDLE. If `ena` is already high at release, the current cycle is treated as byte 0 of a new packet.

## Test plan
- **Type-1 packet, ADDR_W=4:**
  - Stimulus: header 00 00 00 00, payload A1 A2 A3, decoder drives `is_type_1`=1 from byte 4.
  - Required: `wr_en_1` writes A1@0, A2@1, A3@2 on consecutive cycles; `wr_en_2` is never asserted; `pkt_done` with `pkt_len`=3, `pkt_type`=01, `pkt_err`=0.
- **Type-2 packet:**
  - Stimulus: header 01 xx xx xx, payload 55, `is_type_2`=1.
  - Required: single `wr_en_2` with 55@0; `pkt_len`=1, `pkt_type`=10.
- **Unknown type:**
  - Stimulus: header 07..., 6 payload bytes, both flags 0.
  - Required: no write strobes; `pkt_type`=00, `pkt_len`=0, `pkt_err`=1.
- **Short packet and back-to-back:**
  - Stimulus: 3-byte frame, then 1 idle cycle, then a valid type-1 packet with 2 payload bytes.
  - Required: first `pkt_done` has `pkt_err`=1, `pkt_len`=0; second reports `pkt_len`=2, `pkt_type`=01, `pkt_err`=0.
- **Overflow, ADDR_W=4:**
  - Stimulus: type-1 packet with 20 payload bytes.
  - Required: writes at addresses 0..15 only; `pkt_len`=16, `pkt_ovf`=1, `pkt_err`=1.
- **Mid-packet reset:**
  - Stimulus: assert `aclr` during payload byte 2.
  - Required: all outputs go to 0 immediately and there is no `pkt_done`; the next packet routes normally from address 0.
